spi_word_master: RTL and testbench

//  Master-side SPI transmitter feeding the display slave. Accepts a 16-bit word on a

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_half_tick.sv | 34 +++
 rtl/spi_word_master.sv | 160 ++++++++++++++++
 tb/tb_spi_word_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    HOLD,
    GUARD
  } spi_mst_state_t;

  localparam int SPI_BYTES_PER_WORD = 2;
  localparam int SPI_BITS_PER_BYTE  = 8;
  localparam int SPI_WORD_W         = SPI_BYTES_PER_WORD * SPI_BITS_PER_BYTE;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: tick_o marks the last clk cycle of each half-period.
module spi_half_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  // Restart holds the count at zero so the next state starts a full half-period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_word_master.sv
// SPI mode-0 master: one 16-bit word per SS_n frame, low byte first, MSB first in each byte.
// Handshake: a word is taken on any clk edge where tx_valid && tx_ready; tx_ready is
// high only while idle and not on the done cycle, and tx_valid is ignored otherwise.
module spi_word_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_WORD_W-1:0] tx_word,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_WORD_W-1:0] rx_word,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SS_n,
  output spi_mst_state_t        state_o
);

  localparam logic [2:0] BIT_LAST  = 3'(SPI_BITS_PER_BYTE - 1);
  localparam logic       BYTE_LAST = 1'(SPI_BYTES_PER_WORD - 1);

  spi_mst_state_t              state_q, state_d;
  logic [SPI_BITS_PER_BYTE-1:0] word_hi_q, word_hi_d;
  logic [SPI_BITS_PER_BYTE-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_WORD_W-1:0]        rx_sh_q, rx_sh_d;
  logic [SPI_WORD_W-1:0]        rx_word_q, rx_word_d;
  logic [2:0]                   bit_cnt_q, bit_cnt_d;
  logic                         byte_idx_q, byte_idx_d;
  logic                         sclk_q, sclk_d;
  logic                         mosi_q, mosi_d;
  logic                         ss_n_q, ss_n_d;
  logic                         done_q, done_d;
  logic                         tick;

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (state_q == IDLE),
    .tick_o    (tick)
  );

  assign tx_ready = (state_q == IDLE) && !done_q;
  assign busy     = (state_q != IDLE) || done_q;
  assign done     = done_q;
  assign rx_word  = rx_word_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SS_n     = ss_n_q;
  assign state_o  = state_q;

  always_comb begin
    state_d    = state_q;
    word_hi_d  = word_hi_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_word_d  = rx_word_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d    = SETUP;
          word_hi_d  = tx_word[15:8];
          tx_sh_d    = tx_word[7:0];
          mosi_d     = tx_word[7];
          ss_n_d     = 1'b0;
          byte_idx_d = 1'b0;
          bit_cnt_d  = '0;
          sclk_d     = 1'b0;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[SPI_WORD_W-2:0], MISO};
          end else begin
            sclk_d = 1'b0;
            // The last bit of a byte stays on MOSI through the following gap/hold.
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = (byte_idx_q == BYTE_LAST) ? HOLD : GAP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_sh_d   = {tx_sh_q[SPI_BITS_PER_BYTE-2:0], 1'b0};
              mosi_d    = tx_sh_q[SPI_BITS_PER_BYTE-2];
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d    = SHIFT;
          byte_idx_d = 1'b1;
          tx_sh_d    = word_hi_q;
          mosi_d     = word_hi_q[SPI_BITS_PER_BYTE-1];
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GUARD;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      GUARD: begin
        if (tick) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          // First byte shifted in sits in the upper half of the shift register.
          rx_word_d = {rx_sh_q[7:0], rx_sh_q[15:8]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_hi_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_word_q  <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_hi_q  <= word_hi_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_word_q  <= rx_word_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_word_master.sv
// Bench for spi_word_master: frame-position model of the pins, MOSI capture scoreboard.
module tb_spi_word_master;
  import spi_pkg::*;

  localparam int D     = 4;
  localparam int FRAME = 36 * D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]    tx_word = '0;
  logic           tx_valid = 1'b0;
  logic           tx_ready, busy, done;
  logic [15:0]    rx_word;
  logic           SCLK, MOSI, MISO, SS_n;
  spi_mst_state_t dbg_state;
  logic           loopback = 1'b0;
  logic           miso_drv = 1'b0;

  assign MISO = loopback ? MOSI : miso_drv;

  spi_word_master #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_word  (tx_word),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .rx_word  (rx_word),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .state_o  (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy = 1'b0;
  int          m_k = 0;
  logic [15:0] m_w = '0;
  logic [15:0] m_mw = '0;
  logic [15:0] m_rx = '0;
  int          acc_cyc = 0;
  int          n_acc = 0;
  int          n_done = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cap = '0;

  // Pin values at clk offset k (0..FRAME-1) after the accepting edge.
  function automatic void exp_pins(input int k, input logic [15:0] w,
                                   output logic ss, output logic sck, output logic mo);
    int h;
    h = k / D;
    ss = (h >= 35);
    sck = 1'b0;
    mo = 1'b0;
    if (h == 0) mo = w[7];
    else if (h <= 16) begin
      sck = ((h - 1) % 2) == 1;
      mo = w[7 - (h - 1) / 2];
    end else if (h == 17) mo = w[0];
    else if (h <= 33) begin
      sck = ((h - 18) % 2) == 1;
      mo = w[15 - (h - 18) / 2];
    end else if (h == 34) mo = w[8];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_k = 0;
      m_rx = '0;
    end else begin
      cyc++;
      if (m_busy) begin
        m_k++;
        if (m_k == FRAME) m_rx = m_mw;
        if (m_k > FRAME) m_busy = 1'b0;
      end else if (tx_valid) begin
        m_busy = 1'b1;
        m_k = 0;
        m_w = tx_word;
        m_mw = loopback ? tx_word : 16'($urandom);
        acc_cyc = cyc;
        n_acc++;
        exp_q.push_back({tx_word[7:0], tx_word[15:8]});
      end
    end
  end

  always @(negedge clk) begin
    int h;
    h = m_k / D;
    if (m_busy && h >= 1 && h <= 16) miso_drv = m_mw[7 - (h - 1) / 2];
    else if (m_busy && h >= 18 && h <= 33) miso_drv = m_mw[15 - (h - 18) / 2];
    else miso_drv = 1'($urandom);
  end

  always @(posedge SCLK) cap = {cap[14:0], MOSI};

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    logic e_ss, e_sclk, e_mosi;
    logic [15:0] e_cap;
    if (m_busy && m_k < FRAME) exp_pins(m_k, m_w, e_ss, e_sclk, e_mosi);
    else begin
      e_ss = 1'b1;
      e_sclk = 1'b0;
      e_mosi = 1'b0;
    end
    chk1("ss_n", SS_n, e_ss);
    chk1("sclk", SCLK, e_sclk);
    chk1("mosi", MOSI, e_mosi);
    chk1("busy", busy, m_busy);
    chk1("done", done, m_busy && m_k == FRAME);
    chk1("tx_ready", tx_ready, !m_busy);
    chk16("rx_word", rx_word, m_rx);
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk_int("frame_without_accept", 1, 0);
      end else begin
        e_cap = exp_q.pop_front();
        chk16("mosi_frame", cap, e_cap);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [15:0] w, input logic loop);
    int n0, t;
    loopback = loop;
    tx_word = w;
    tx_valid = 1'b1;
    n0 = n_acc;
    t = 0;
    while (n_acc == n0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    tx_valid = 1'b0;
    chk1("accept_seen", n_acc != n0, 1'b1);
  endtask

  task automatic wait_done(output int lat);
    int t;
    t = 0;
    while (done !== 1'b1 && t < FRAME + 20) begin
      @(negedge clk);
      t++;
    end
    chk1("done_seen", done, 1'b1);
    lat = cyc - acc_cyc;
  endtask

  task automatic poke_busy();
    @(negedge clk);
    tx_word = 16'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, t;
    int acc[3];
    logic [15:0] words[3];
    logic [15:0] w;

    repeat (3) @(negedge clk);
    chk1("reset_ss_n", SS_n, 1'b1);
    chk1("reset_sclk", SCLK, 1'b0);
    chk1("reset_mosi", MOSI, 1'b0);
    chk1("reset_tx_ready", tx_ready, 1'b1);
    chk16("reset_rx_word", rx_word, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Byte order and latency
    send_word(16'h1234, 1'b0);
    wait_done(lat);
    chk_int("latency", lat, 144);
    chk16("bytes_1234", cap, 16'h3412);
    @(negedge clk);

    // Loopback
    send_word(16'hA55A, 1'b1);
    wait_done(lat);
    chk16("loopback_rx", rx_word, 16'hA55A);
    @(negedge clk);
    chk1("busy_after_done", busy, 1'b0);
    loopback = 1'b0;

    // Back-to-back words with tx_valid held high
    words[0] = 16'h0001;
    words[1] = 16'h2710;
    words[2] = 16'hFFFF;
    t = n_done;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n0, b;
      tx_word = words[i];
      n0 = n_acc;
      b = 0;
      while (n_acc == n0 && b < 300) begin
        @(negedge clk);
        b++;
      end
      chk1("queued_accept", n_acc != n0, 1'b1);
      acc[i] = acc_cyc;
    end
    tx_valid = 1'b0;
    wait_done(lat);
    chk16("bytes_ffff", cap, 16'hFFFF);
    @(negedge clk);
    chk_int("queued_frames", n_done - t, 3);
    chk_int("accept_gap_0", acc[1] - acc[0], FRAME + 2);
    chk_int("accept_gap_1", acc[2] - acc[1], FRAME + 2);

    // Reset in the middle of the second byte, with SCLK high
    send_word(16'hBEEF, 1'b0);
    t = 0;
    while (m_k != 23 * D + 1 && t < FRAME) begin
      @(negedge clk);
      t++;
    end
    chk1("pre_reset_sclk", SCLK, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("midreset_ss_n", SS_n, 1'b1);
    chk1("midreset_sclk", SCLK, 1'b0);
    chk1("midreset_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_reset_ready", tx_ready, 1'b1);
    send_word(16'h00FF, 1'b0);
    wait_done(lat);
    chk16("bytes_00ff", cap, 16'hFF00);
    @(negedge clk);

    // Input changes while busy are ignored
    send_word(16'hC3E1, 1'b0);
    repeat (3) poke_busy();
    repeat (20) @(negedge clk);
    poke_busy();
    wait_done(lat);
    chk16("bytes_c3e1", cap, 16'hE1C3);
    @(negedge clk);

    // Random frames
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = 16'($urandom);
      send_word(w, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        poke_busy();
      end
      wait_done(lat);
      chk_int("rand_latency", lat, FRAME);
      @(negedge clk);
      loopback = 1'b0;
    end

    repeat (4) @(negedge clk);
    chk_int("leftover_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
